// File: rtl/tm_pkg.sv
// Shared types and constants for the Turing-machine engine.
package tm_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_RD,
    S_RD_W,
    S_EXEC,
    S_WR,
    S_WR_W,
    S_CHK,
    S_DONE
  } fsm_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam int DEF_STATE_W = 2;
  localparam int DEF_SYM_W   = 3;

  // Rule word layout at the default geometry: {newsym, dir, next}.
  typedef struct packed {
    logic [DEF_SYM_W-1:0]   newsym;
    logic                   dir;
    logic [DEF_STATE_W-1:0] next;
  } rule_t;

  // The top state code is reserved as HALT.
  function automatic int halt_code(input int state_w);
    return (1 << state_w) - 1;
  endfunction

endpackage

// File: rtl/tm_if.sv
// Request/ack handshake towards the tape DRAM controller.
interface tm_if #(
  parameter int ADDR_W = 16
);
  logic              m_write;
  logic              m_ena;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        wr_data;
  logic [7:0]        rd_data;
  logic              m_busy;
  logic              m_ack;

  modport master (
    output m_write, m_ena, m_addr, wr_data,
    input  rd_data, m_busy, m_ack
  );

  modport slave (
    input  m_write, m_ena, m_addr, wr_data,
    output rd_data, m_busy, m_ack
  );
endinterface

// File: rtl/tm_rule_table.sv
// Transition table indexed by {state, sym}: one synchronous write port, combinational read.
module tm_rule_table
  import tm_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] entries [2**AW];

  // Contents survive reset so a loaded machine can be rerun.
  always_ff @(posedge clk) begin
    if (we) entries[waddr] <= wdata;
  end

  assign rdata = entries[raddr];
endmodule

// File: rtl/tm_engine.sv
// Run-time programmable Turing-machine engine with the tape in external DRAM.
module tm_engine
  import tm_pkg::*;
#(
  parameter int STATE_W = 2,
  parameter int SYM_W   = 3,
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 32,
  parameter int SKIP_WR = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CNT_W-1:0]           step_limit,
  input  logic                       rule_we,
  input  logic [STATE_W+SYM_W-1:0]   rule_addr,
  input  logic [SYM_W+STATE_W:0]     rule_data,
  tm_if.master                       mem,
  output logic [CNT_W-1:0]           step_count,
  output logic [CNT_W-1:0]           sigma,
  output logic                       running,
  output logic                       halted,
  output logic                       limit_hit,
  output logic                       tape_err
);
  localparam logic [STATE_W-1:0] HALT      = STATE_W'(halt_code(STATE_W));
  localparam logic [ADDR_W-1:0]  HEAD_HOME = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]  ADDR_MAX  = '1;

  fsm_t               fsm_reg;
  logic [STATE_W-1:0] state_reg;
  logic [ADDR_W-1:0]  head_reg, clr_addr_reg, m_addr_reg;
  logic [SYM_W-1:0]   sym_reg, newsym_reg;
  logic               dir_reg, acked_reg, m_ena_reg, m_write_reg;
  logic [7:0]         wr_data_reg;
  logic [CNT_W-1:0]   step_count_reg, sigma_reg, step_next;
  logic               running_reg, halted_reg, limit_hit_reg, tape_err_reg;
  logic [SYM_W+STATE_W:0] rule_word;
  logic [SYM_W-1:0]   rule_newsym;
  logic               rule_dir, at_edge, unused_rd;
  logic [STATE_W-1:0] rule_next;

  tm_rule_table #(.AW(STATE_W + SYM_W), .DW(SYM_W + 1 + STATE_W)) u_rules (
    .clk   (clk),
    .we    (rule_we && (fsm_reg == S_IDLE || fsm_reg == S_DONE)),
    .waddr (rule_addr),
    .wdata (rule_data),
    .raddr ({state_reg, sym_reg}),
    .rdata (rule_word)
  );

  assign rule_newsym = rule_word[SYM_W+STATE_W -: SYM_W];
  assign rule_dir    = rule_word[STATE_W];
  assign rule_next   = rule_word[STATE_W-1:0];
  assign step_next   = (step_count_reg == '1) ? step_count_reg : step_count_reg + 1'b1;
  assign at_edge     = (dir_reg == DIR_R) ? (head_reg == ADDR_MAX) : (head_reg == '0);
  assign unused_rd   = ^mem.rd_data[7:SYM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg        <= S_IDLE;
      state_reg      <= '0;
      head_reg       <= HEAD_HOME;
      clr_addr_reg   <= '0;
      m_addr_reg     <= '0;
      sym_reg        <= '0;
      newsym_reg     <= '0;
      dir_reg        <= 1'b0;
      acked_reg      <= 1'b0;
      m_ena_reg      <= 1'b0;
      m_write_reg    <= 1'b0;
      wr_data_reg    <= '0;
      step_count_reg <= '0;
      sigma_reg      <= '0;
      running_reg    <= 1'b0;
      halted_reg     <= 1'b0;
      limit_hit_reg  <= 1'b0;
      tape_err_reg   <= 1'b0;
    end else begin
      case (fsm_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            fsm_reg        <= S_CLR;
            running_reg    <= 1'b1;
            halted_reg     <= 1'b0;
            limit_hit_reg  <= 1'b0;
            tape_err_reg   <= 1'b0;
            sigma_reg      <= '0;
            state_reg      <= '0;
            head_reg       <= HEAD_HOME;
            clr_addr_reg   <= ADDR_MAX;
            acked_reg      <= 1'b0;
            step_count_reg <= CNT_W'(ADDR_MAX);
          end
        end
        // Clear sweeps top-down; step_count mirrors the address for the display.
        S_CLR: begin
          if (m_ena_reg) begin
            if (mem.m_ack) begin
              m_ena_reg <= 1'b0;
              acked_reg <= 1'b1;
            end
          end else if (!acked_reg) begin
            m_ena_reg   <= 1'b1;
            m_write_reg <= 1'b1;
            m_addr_reg  <= clr_addr_reg;
            wr_data_reg <= '0;
          end else if (!mem.m_busy) begin
            acked_reg <= 1'b0;
            if (clr_addr_reg == '0) begin
              fsm_reg        <= S_RD;
              step_count_reg <= '0;
            end else begin
              clr_addr_reg   <= clr_addr_reg - 1'b1;
              step_count_reg <= CNT_W'(clr_addr_reg - 1'b1);
            end
          end
        end
        S_RD: begin
          m_ena_reg   <= 1'b1;
          m_write_reg <= 1'b0;
          m_addr_reg  <= head_reg;
          fsm_reg     <= S_RD_W;
        end
        S_RD_W: begin
          if (m_ena_reg) begin
            if (mem.m_ack) m_ena_reg <= 1'b0;
          end else if (!mem.m_busy) begin
            sym_reg <= mem.rd_data[SYM_W-1:0];
            fsm_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          newsym_reg <= rule_newsym;
          dir_reg    <= rule_dir;
          state_reg  <= rule_next;
          fsm_reg    <= (SKIP_WR != 0 && rule_newsym == sym_reg) ? S_CHK : S_WR;
        end
        S_WR: begin
          m_ena_reg   <= 1'b1;
          m_write_reg <= 1'b1;
          m_addr_reg  <= head_reg;
          wr_data_reg <= {{(8-SYM_W){1'b0}}, newsym_reg};
          fsm_reg     <= S_WR_W;
        end
        S_WR_W: begin
          if (m_ena_reg) begin
            if (mem.m_ack) m_ena_reg <= 1'b0;
          end else if (!mem.m_busy) begin
            fsm_reg <= S_CHK;
          end
        end
        S_CHK: begin
          step_count_reg <= step_next;
          if (sym_reg == '0 && newsym_reg != '0) begin
            if (sigma_reg != '1) sigma_reg <= sigma_reg + 1'b1;
          end else if (sym_reg != '0 && newsym_reg == '0 && sigma_reg != '0) begin
            sigma_reg <= sigma_reg - 1'b1;
          end
          if (state_reg == HALT) begin
            halted_reg  <= 1'b1;
            running_reg <= 1'b0;
            fsm_reg     <= S_DONE;
          end else if (step_limit != '0 && step_next >= step_limit) begin
            limit_hit_reg <= 1'b1;
            running_reg   <= 1'b0;
            fsm_reg       <= S_DONE;
          end else if (at_edge) begin
            tape_err_reg <= 1'b1;
            running_reg  <= 1'b0;
            fsm_reg      <= S_DONE;
          end else if (abort) begin
            running_reg <= 1'b0;
            fsm_reg     <= S_IDLE;
          end else begin
            head_reg <= (dir_reg == DIR_R) ? head_reg + 1'b1 : head_reg - 1'b1;
            fsm_reg  <= S_RD;
          end
        end
        default: fsm_reg <= S_IDLE;
      endcase
    end
  end

  assign mem.m_ena   = m_ena_reg;
  assign mem.m_write = m_write_reg;
  assign mem.m_addr  = m_addr_reg;
  assign mem.wr_data = wr_data_reg;
  assign step_count  = step_count_reg;
  assign sigma       = sigma_reg;
  assign running     = running_reg;
  assign halted      = halted_reg;
  assign limit_hit   = limit_hit_reg;
  assign tape_err    = tape_err_reg;
endmodule

// File: tb/tb_tm_engine.sv
// Bench for tm_engine: random-latency DRAM model plus a plain tape-walking reference machine.
module tb_tm_engine;
  import tm_pkg::*;

  localparam int AW    = 4;
  localparam int NCELL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rule_we = 1'b0;
  logic [31:0] step_limit = '0;
  logic [4:0]  rule_addr = '0;
  logic [5:0]  rule_data = '0;
  logic [31:0] step_count, sigma;
  logic        running, halted, limit_hit, tape_err;

  tm_if #(.ADDR_W(AW)) mif();

  tm_engine #(.STATE_W(2), .SYM_W(3), .ADDR_W(AW), .CNT_W(32), .SKIP_WR(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .step_limit(step_limit),
    .rule_we(rule_we), .rule_addr(rule_addr), .rule_data(rule_data), .mem(mif),
    .step_count(step_count), .sigma(sigma), .running(running), .halted(halted),
    .limit_hit(limit_hit), .tape_err(tape_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0, wr_cnt = 0, stab_err = 0, ph = 0, lat = 0, tail = 0, base_wr = 0;
  logic [AW-1:0] last_addr = '0, q_addr = '0;
  logic          q_wr = 1'b0;
  logic [7:0]    q_data = '0;
  logic [7:0]    dram [NCELL];

  // DRAM controller model: ack 1-4 cycles after the request is seen, busy tail 2-6 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mif.m_ack  <= 1'b0;
      mif.m_busy <= 1'b0;
      mif.rd_data <= '0;
      ph <= 0;
    end else begin
      mif.m_ack <= 1'b0;
      case (ph)
        0: if (mif.m_ena) begin
          q_addr <= mif.m_addr; q_wr <= mif.m_write; q_data <= mif.wr_data;
          lat <= $urandom_range(0, 3); ph <= 1;
        end
        1: if (lat > 0) lat <= lat - 1;
        else begin
          if ({mif.m_ena, mif.m_addr, mif.m_write, mif.wr_data} !== {1'b1, q_addr, q_wr, q_data})
            stab_err <= stab_err + 1;
          mif.m_ack <= 1'b1; mif.m_busy <= 1'b1; last_addr <= q_addr;
          tail <= $urandom_range(1, 5); ph <= 2;
          if (q_wr) begin
            dram[q_addr] <= q_data; wr_cnt <= wr_cnt + 1;
          end else begin
            mif.rd_data <= {5'($urandom), dram[q_addr][2:0]}; rd_cnt <= rd_cnt + 1;
          end
        end
        default: if (tail > 0) tail <= tail - 1;
        else begin
          mif.m_busy <= 1'b0; ph <= 0;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [5:0] rules [32];
  int m_steps, m_sigma, m_writes;
  bit m_halt, m_lim, m_err;
  logic [2:0] m_tape [NCELL];

  function automatic logic [5:0] mk(input int ns, input logic d, input int nx);
    rule_t r;
    r.newsym = 3'(ns); r.dir = d; r.next = 2'(nx);
    return r;
  endfunction

  // Reference: walk the tape step by step, stop by halt > limit > edge > abort.
  function automatic void model_run(input int limit, input int abort_k);
    int head, st, sym, ns, nx;
    logic [5:0] w;
    bit stop;
    for (int i = 0; i < NCELL; i++) m_tape[i] = '0;
    head = NCELL / 2; st = 0; stop = 0;
    m_steps = 0; m_writes = NCELL; m_halt = 0; m_lim = 0; m_err = 0;
    while (!stop && m_steps < 100000) begin
      sym = int'(m_tape[head]);
      w = rules[st * 8 + sym];
      ns = int'(w[5:3]); nx = int'(w[1:0]);
      if (ns != sym) m_writes++;
      m_tape[head] = 3'(ns); m_steps++; st = nx;
      if (nx == 3) begin m_halt = 1; stop = 1; end
      else if (limit != 0 && m_steps >= limit) begin m_lim = 1; stop = 1; end
      else if ((w[2] && head == NCELL - 1) || (!w[2] && head == 0)) begin m_err = 1; stop = 1; end
      else if (abort_k != 0 && m_steps >= abort_k) stop = 1;
      else head += w[2] ? 1 : -1;
    end
    m_sigma = 0;
    for (int i = 0; i < NCELL; i++) if (m_tape[i] != 0) m_sigma++;
  endfunction

  task automatic load_rules();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); rule_we = 1'b1; rule_addr = 5'(i); rule_data = rules[i];
    end
    @(negedge clk); rule_we = 1'b0;
  endtask

  task automatic run_machine(input int limit, input int abort_k, input bit inject);
    int base_rd, cyc;
    bit injected;
    base_rd = rd_cnt; base_wr = wr_cnt; injected = 0; cyc = 0;
    step_limit = 32'(limit);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("running_after_start", running, 1);
    check("clr_addr_display", step_count, NCELL - 1);
    while (running && cyc < 20000) begin
      @(negedge clk); cyc++;
      rule_we = 1'b0;
      if (abort_k > 0 && rd_cnt - base_rd >= abort_k) abort = 1'b1;
      if (inject && !injected && rd_cnt - base_rd >= 2) begin
        rule_we = 1'b1; rule_addr = '0; rule_data = 6'h3f; injected = 1;
      end
    end
    rule_we = 1'b0; abort = 1'b0;
    check("run_stopped", running, 0);
  endtask

  task automatic verify(input string tag, input int limit, input int abort_k);
    logic [3*NCELL-1:0] got_t, exp_t;
    model_run(limit, abort_k);
    for (int i = 0; i < NCELL; i++) begin
      got_t[3*i +: 3] = dram[i][2:0];
      exp_t[3*i +: 3] = m_tape[i];
    end
    check({tag, "_steps"}, step_count, m_steps);
    check({tag, "_sigma"}, sigma, m_sigma);
    check({tag, "_halted"}, halted, m_halt);
    check({tag, "_limit"}, limit_hit, m_lim);
    check({tag, "_tape_err"}, tape_err, m_err);
    check({tag, "_writes"}, wr_cnt - base_wr, m_writes);
    check({tag, "_tape"}, got_t, exp_t);
    check({tag, "_m_ena_idle"}, mif.m_ena, 0);
    check({tag, "_req_stable"}, stab_err, 0);
    $display("run %s: steps=%0d sigma=%0d halted=%0d limit=%0d tape_err=%0d",
             tag, step_count, sigma, halted, limit_hit, tape_err);
  endtask

  task automatic set_bb2();
    for (int i = 0; i < 32; i++) rules[i] = '0;
    rules[0] = mk(1, DIR_R, 1); rules[1] = mk(1, DIR_L, 1);
    rules[8] = mk(1, DIR_L, 0); rules[9] = mk(1, DIR_R, 3);
  endtask

  initial begin
    int found, nsym, lim;
    for (int i = 0; i < NCELL; i++) dram[i] = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_step_count", step_count, 0);
    check("rst_sigma", sigma, 0);
    check("rst_flags", {running, halted, limit_hit, tape_err}, 0);
    check("rst_mem", {mif.m_ena, mif.m_write, mif.m_addr, mif.wr_data}, 0);
    rst_n = 1'b1;

    set_bb2(); load_rules();
    run_machine(0, 0, 0);
    verify("bb2", 0, 0);
    check("bb2_steps_const", step_count, 6);
    check("bb2_sigma_const", sigma, 4);
    check("bb2_halted_const", {halted, tape_err}, 2'b10);

    rules[1] = '0; rules[8] = '0; rules[9] = '0; rules[0] = mk(1, DIR_R, 0);
    load_rules();
    run_machine(0, 0, 0);
    verify("right_edge", 0, 0);
    check("edge_steps_const", step_count, 8);
    check("edge_tape_err_const", tape_err, 1);
    check("edge_last_addr", last_addr, NCELL - 1);

    for (int i = 0; i < 32; i++) rules[i] = '0;
    rules[0] = mk(1, DIR_R, 1); rules[1] = mk(3, DIR_L, 0); rules[2] = mk(4, DIR_L, 0);
    rules[3] = mk(1, DIR_R, 0); rules[4] = mk(1, DIR_L, 0);
    rules[8] = mk(2, DIR_L, 0); rules[9] = mk(1, DIR_R, 3); rules[10] = mk(4, DIR_R, 0);
    rules[11] = mk(3, DIR_R, 1); rules[12] = mk(1, DIR_R, 0);
    load_rules();
    run_machine(30, 0, 0);
    verify("m11k_lim", 30, 0);
    run_machine(30, 0, 0);
    verify("m11k_restart", 30, 0);
    run_machine(0, 3, 0);
    verify("abort", 0, 3);
    check("abort_steps_const", step_count, 3);
    check("abort_no_flags", {halted, limit_hit, tape_err}, 0);

    set_bb2(); load_rules();
    run_machine(3, 0, 0);
    verify("bb2_lim3", 3, 0);
    check("lim3_flag_const", {halted, limit_hit}, 2'b01);
    run_machine(0, 0, 1);
    verify("bb2_rule_we_run", 0, 0);

    step_limit = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      @(negedge clk);
      if (mif.m_ena && !mif.m_write) found = 1;
    end
    check("rd_req_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_m_ena", mif.m_ena, 0);
    check("async_rst_outputs", {step_count, sigma, running, halted, limit_hit, tape_err}, 0);
    @(negedge clk); rst_n = 1'b1;
    run_machine(0, 0, 0);
    verify("bb2_after_rst", 0, 0);

    for (int r = 0; r < 8; r++) begin
      nsym = $urandom_range(2, 4);
      for (int i = 0; i < 32; i++)
        rules[i] = mk($urandom_range(0, nsym - 1), 1'($urandom), $urandom_range(0, 3));
      load_rules();
      lim = $urandom_range(1, 40);
      run_machine(lim, 0, 0);
      verify($sformatf("rand%0d", r), lim, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
